// File: rtl/cpu_pkg.sv
// Shared definitions for the multi-cycle R-type controller: ALU operation
// codes, R-type funct codes, FSM state encodings and default address width.
package cpu_pkg;

  // Default register-file address width; the 5-bit instruction fields
  // zero-extend when a wider register file is attached.
  localparam int REG_ADDR_W_DEF = 5;

  // ALU operation select codes driven on ALU_OP.
  localparam logic [2:0] ALU_AND  = 3'b000;
  localparam logic [2:0] ALU_OR   = 3'b001;
  localparam logic [2:0] ALU_XOR  = 3'b010;
  localparam logic [2:0] ALU_NOR  = 3'b011;
  localparam logic [2:0] ALU_ADD  = 3'b100;
  localparam logic [2:0] ALU_SUB  = 3'b101;
  localparam logic [2:0] ALU_SLTU = 3'b110;
  localparam logic [2:0] ALU_SLLV = 3'b111;

  // Instruction encodings recognised by the decoder.
  localparam logic [5:0] OPCODE_RTYPE = 6'h00;
  localparam logic [5:0] FUNCT_AND    = 6'h24;
  localparam logic [5:0] FUNCT_OR     = 6'h25;
  localparam logic [5:0] FUNCT_XOR    = 6'h26;
  localparam logic [5:0] FUNCT_NOR    = 6'h27;
  localparam logic [5:0] FUNCT_ADD    = 6'h20;
  localparam logic [5:0] FUNCT_SUB    = 6'h22;
  localparam logic [5:0] FUNCT_SLTU   = 6'h2B;
  localparam logic [5:0] FUNCT_SLLV   = 6'h04;

  // Controller state encodings, kept as plain constants so the encoding is
  // fixed and visible in waveforms of older tools.
  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE   = 2'd0;
  localparam state_t ST_DECODE = 2'd1;
  localparam state_t ST_EXEC   = 2'd2;
  localparam state_t ST_WB     = 2'd3;

  // True for the signed arithmetic operations that can raise overflow.
  function automatic logic is_addsub(input logic [2:0] op);
    return (op == ALU_ADD) || (op == ALU_SUB);
  endfunction

endpackage

// File: rtl/cpu_ctrl_if.sv
// Bus between the instruction source / datapath and the R-type controller.
// The master side is the environment (instruction source plus ALU flag
// outputs); the slave side is the controller itself.
interface cpu_ctrl_if #(
  parameter int REG_ADDR_W = 5
);

  // Instruction handshake
  logic                  inst_valid;
  logic [31:0]           Inst_code;
  logic                  inst_ready;

  // Register-file and ALU control
  logic [REG_ADDR_W-1:0] R_Addr_A;
  logic [REG_ADDR_W-1:0] R_Addr_B;
  logic [REG_ADDR_W-1:0] W_Addr;
  logic                  Write_Reg;
  logic [2:0]            ALU_OP;

  // ALU flags in, latched flags out
  logic                  ALU_ZF;
  logic                  ALU_OF;
  logic                  ZF;
  logic                  OF;

  // Status pulses
  logic                  done;
  logic                  illegal;

  modport master (
    output inst_valid, Inst_code, ALU_ZF, ALU_OF,
    input  inst_ready, R_Addr_A, R_Addr_B, W_Addr, Write_Reg, ALU_OP,
    input  ZF, OF, done, illegal
  );

  modport slave (
    input  inst_valid, Inst_code, ALU_ZF, ALU_OF,
    output inst_ready, R_Addr_A, R_Addr_B, W_Addr, Write_Reg, ALU_OP,
    output ZF, OF, done, illegal
  );

endinterface

// File: rtl/cpu_decode.sv
// Combinational R-type decoder: maps opcode/funct to an ALU operation and
// flags anything outside the supported set as not legal.
module cpu_decode
  import cpu_pkg::*;
(
  input  logic [5:0] opcode_i,
  input  logic [5:0] funct_i,
  output logic [2:0] alu_op_o,
  output logic       legal_o
);

  // Funct lookup; an unknown funct or a non-R-type opcode is not legal.
  always_comb begin
    alu_op_o = ALU_AND;
    legal_o  = 1'b1;
    unique case (funct_i)
      FUNCT_AND:  alu_op_o = ALU_AND;
      FUNCT_OR:   alu_op_o = ALU_OR;
      FUNCT_XOR:  alu_op_o = ALU_XOR;
      FUNCT_NOR:  alu_op_o = ALU_NOR;
      FUNCT_ADD:  alu_op_o = ALU_ADD;
      FUNCT_SUB:  alu_op_o = ALU_SUB;
      FUNCT_SLTU: alu_op_o = ALU_SLTU;
      FUNCT_SLLV: alu_op_o = ALU_SLLV;
      default:    legal_o  = 1'b0;
    endcase
    if (opcode_i != OPCODE_RTYPE) begin
      legal_o = 1'b0;
    end
  end

endmodule

// File: rtl/cpu_ctrl.sv
// Multi-cycle controller for the R-type datapath. One instruction is taken
// over a valid/ready handshake and sequenced IDLE -> DECODE -> EXEC -> WB;
// illegal instructions return from DECODE straight to IDLE.
// Optional feature macro: CPU_CTRL_OF_TRAP_EN -- when defined, ADD/SUB with
// overflow suppress the write-back and raise illegal alongside done.
module cpu_ctrl
  import cpu_pkg::*;
#(
  parameter int REG_ADDR_W = REG_ADDR_W_DEF
) (
  input  logic        clk,
  input  logic        rst,
  cpu_ctrl_if.slave   bus
);

  // ---------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------
  state_t                state_q, state_d;
  logic [31:0]           ir_q, ir_d;
  logic [REG_ADDR_W-1:0] ra_q, rb_q, wa_q;
  logic [2:0]            op_q;
  logic                  zf_q, zf_d;
  logic                  of_q, of_d;

  // Current-cycle control values (driven from ir while busy, held otherwise)
  logic [REG_ADDR_W-1:0] ra_cur, rb_cur, wa_cur;
  logic [2:0]            op_cur;

  logic [2:0]            dec_op;
  logic                  dec_legal;
  logic                  busy;
  logic                  accept;
  logic                  trap;

  // Shift amount is not used by any supported operation.
  logic                  unused_shamt;
  assign unused_shamt = ^ir_q[10:6];

  // ---------------------------------------------------------------------
  // Decoder works on the latched instruction, so its result is valid from
  // DECODE onwards and stays stable through EXEC and WB.
  // ---------------------------------------------------------------------
  cpu_decode u_decode (
    .opcode_i (ir_q[31:26]),
    .funct_i  (ir_q[5:0]),
    .alu_op_o (dec_op),
    .legal_o  (dec_legal)
  );

  assign busy   = (state_q != ST_IDLE);
  assign accept = bus.inst_valid && (state_q == ST_IDLE);

`ifdef CPU_CTRL_OF_TRAP_EN
  // Overflow on signed add/sub aborts the write-back.
  assign trap = is_addsub(op_cur) && of_q;
`else
  // Overflow is only reported through OF.
  assign trap = 1'b0;
`endif

  // Address and ALU_OP selection: follow ir while busy, otherwise hold
  always_comb begin
    ra_cur = ra_q;
    rb_cur = rb_q;
    wa_cur = wa_q;
    op_cur = op_q;
    if (busy) begin
      ra_cur = REG_ADDR_W'(ir_q[25:21]);
      rb_cur = REG_ADDR_W'(ir_q[20:16]);
      wa_cur = REG_ADDR_W'(ir_q[15:11]);
      if (dec_legal) begin
        op_cur = dec_op;
      end
    end
  end

  // Next-state sequencing and instruction/flag capture
  always_comb begin
    state_d = state_q;
    ir_d    = ir_q;
    zf_d    = zf_q;
    of_d    = of_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          ir_d    = bus.Inst_code;
          state_d = ST_DECODE;
        end
      end
      ST_DECODE: begin
        state_d = dec_legal ? ST_EXEC : ST_IDLE;
      end
      ST_EXEC: begin
        zf_d    = bus.ALU_ZF;
        of_d    = bus.ALU_OF;
        state_d = ST_WB;
      end
      ST_WB: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Register update; reset aborts any in-flight instruction immediately
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      ir_q    <= '0;
      ra_q    <= '0;
      rb_q    <= '0;
      wa_q    <= '0;
      op_q    <= ALU_AND;
      zf_q    <= 1'b0;
      of_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
      ra_q    <= ra_cur;
      rb_q    <= rb_cur;
      wa_q    <= wa_cur;
      op_q    <= op_cur;
      zf_q    <= zf_d;
      of_q    <= of_d;
    end
  end

  // ---------------------------------------------------------------------
  // Outputs: pulses decode directly from state so reset clears them at once
  // ---------------------------------------------------------------------
  assign bus.inst_ready = (state_q == ST_IDLE);
  assign bus.R_Addr_A   = ra_cur;
  assign bus.R_Addr_B   = rb_cur;
  assign bus.W_Addr     = wa_cur;
  assign bus.ALU_OP     = op_cur;
  assign bus.ZF         = zf_q;
  assign bus.OF         = of_q;
  assign bus.done       = (state_q == ST_WB);
  // r0 is hard-wired zero, so a write to it is dropped.
  assign bus.Write_Reg  = (state_q == ST_WB) && (wa_cur != '0) && !trap;
  assign bus.illegal    = ((state_q == ST_DECODE) && !dec_legal) ||
                          ((state_q == ST_WB) && trap);

endmodule

// File: tb/tb_cpu_ctrl.sv
// Directed bench for cpu_ctrl: NOR/ADD/SUB sequences, back-to-back
// throughput, illegal opcode/funct, rd=0, overflow handling and reset abort.
module tb_cpu_ctrl;
  import cpu_pkg::*;

  logic clk;
  logic rst;
  int   total;
  int   bad;

`ifdef CPU_CTRL_OF_TRAP_EN
  localparam logic OF_WR  = 1'b0;
  localparam logic OF_ILL = 1'b1;
`else
  localparam logic OF_WR  = 1'b1;
  localparam logic OF_ILL = 1'b0;
`endif

  cpu_ctrl_if #(.REG_ADDR_W(5)) bus ();

  cpu_ctrl #(.REG_ADDR_W(5)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got,
                          input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end else begin
      $display("ok   %s = %0h", tag, got);
    end
  endtask

  // Offer one legal instruction and check it through all four cycles.
  task automatic run_legal(input string tag, input logic [31:0] inst,
                           input logic [2:0] op, input logic [4:0] ra,
                           input logic [4:0] rb, input logic [4:0] wa,
                           input logic wr, input logic zf_in,
                           input logic of_in, input logic ill_wb);
    @(negedge clk);
    check_eq({tag, "_ready"}, bus.inst_ready, 1);
    bus.inst_valid = 1'b1;
    bus.Inst_code  = inst;
    @(negedge clk);                 // DECODE
    bus.inst_valid = 1'b0;
    check_eq({tag, "_dec_op"}, bus.ALU_OP, op);
    check_eq({tag, "_dec_ra"}, bus.R_Addr_A, ra);
    check_eq({tag, "_dec_rb"}, bus.R_Addr_B, rb);
    check_eq({tag, "_dec_wa"}, bus.W_Addr, wa);
    check_eq({tag, "_dec_busy"}, {bus.inst_ready, bus.Write_Reg, bus.done, bus.illegal}, 0);
    @(negedge clk);                 // EXEC
    bus.ALU_ZF = zf_in;
    bus.ALU_OF = of_in;
    check_eq({tag, "_ex_op"}, bus.ALU_OP, op);
    check_eq({tag, "_ex_wr"}, {bus.Write_Reg, bus.done}, 0);
    @(negedge clk);                 // WB
    bus.ALU_ZF = 1'b0;
    bus.ALU_OF = 1'b0;
    check_eq({tag, "_wb_op"}, bus.ALU_OP, op);
    check_eq({tag, "_wb_wa"}, bus.W_Addr, wa);
    check_eq({tag, "_wb_wr"}, bus.Write_Reg, wr);
    check_eq({tag, "_wb_done"}, bus.done, 1);
    check_eq({tag, "_wb_ill"}, bus.illegal, ill_wb);
    check_eq({tag, "_wb_flags"}, {bus.ZF, bus.OF}, {zf_in, of_in});
    @(negedge clk);                 // back in IDLE
    check_eq({tag, "_idle"}, {bus.inst_ready, bus.Write_Reg, bus.done}, 3'b100);
  endtask

  // Offer an illegal instruction; flags must keep the given values.
  task automatic run_illegal(input string tag, input logic [31:0] inst,
                             input logic zf_exp, input logic of_exp);
    @(negedge clk);
    bus.inst_valid = 1'b1;
    bus.Inst_code  = inst;
    @(negedge clk);                 // N+1
    bus.inst_valid = 1'b0;
    check_eq({tag, "_ill"}, bus.illegal, 1);
    check_eq({tag, "_ill_wr"}, {bus.Write_Reg, bus.done, bus.inst_ready}, 0);
    @(negedge clk);                 // N+2
    check_eq({tag, "_after"}, {bus.inst_ready, bus.illegal, bus.Write_Reg}, 3'b100);
    check_eq({tag, "_flags"}, {bus.ZF, bus.OF}, {zf_exp, of_exp});
  endtask

  initial begin
    int gap;
    total          = 0;
    bad            = 0;
    rst            = 1'b0;
    bus.inst_valid = 1'b0;
    bus.Inst_code  = 32'h0;
    bus.ALU_ZF     = 1'b0;
    bus.ALU_OF     = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_eq("rst_ready", bus.inst_ready, 1);
    check_eq("rst_addr", {bus.R_Addr_A, bus.R_Addr_B, bus.W_Addr}, 0);
    check_eq("rst_op", bus.ALU_OP, 0);
    check_eq("rst_out", {bus.Write_Reg, bus.ZF, bus.OF, bus.done, bus.illegal}, 0);

    // NOR r1 = r0 nor r0
    run_legal("nor", 32'h0000_0827, ALU_NOR, 5'd0, 5'd0, 5'd1, 1'b1, 1'b0, 1'b0, 1'b0);

    // Back-to-back ADD then SUB with valid held high
    @(negedge clk);
    bus.inst_valid = 1'b1;
    bus.Inst_code  = 32'h0022_1820;
    check_eq("b2b_ready", bus.inst_ready, 1);
    @(negedge clk);                 // ADD DECODE
    bus.Inst_code = 32'h0022_1822;
    check_eq("b2b_add_op", bus.ALU_OP, ALU_ADD);
    check_eq("b2b_add_wa", bus.W_Addr, 3);
    gap = 1;
    while (!bus.inst_ready && gap < 10) begin
      @(negedge clk);
      gap++;
      if (gap == 3) check_eq("b2b_add_wb", {bus.Write_Reg, bus.done}, 2'b11);
    end
    check_eq("b2b_gap", gap, 4);
    @(negedge clk);                 // SUB DECODE
    bus.inst_valid = 1'b0;
    check_eq("b2b_sub_op", bus.ALU_OP, ALU_SUB);
    check_eq("b2b_sub_wa", bus.W_Addr, 3);
    repeat (2) @(negedge clk);      // SUB WB
    check_eq("b2b_sub_wb", {bus.Write_Reg, bus.done, bus.ALU_OP}, {2'b11, ALU_SUB});
    @(negedge clk);

    // ADD setting ZF, then illegal opcode must leave ZF=1/OF=0
    run_legal("add_zf", 32'h0022_1820, ALU_ADD, 5'd1, 5'd2, 5'd3, 1'b1, 1'b1, 1'b0, 1'b0);
    run_illegal("bad_opc", 32'h2022_1820, 1'b1, 1'b0);

    // ADD with overflow
    run_legal("add_of", 32'h0022_1820, ALU_ADD, 5'd1, 5'd2, 5'd3, OF_WR, 1'b0, 1'b1, OF_ILL);
    run_illegal("bad_fn", 32'h0022_183F, 1'b0, 1'b1);

    // rd = 0: done without a write
    run_legal("rd0", 32'h0022_0020, ALU_ADD, 5'd1, 5'd2, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);

    // Reset during EXEC aborts the instruction
    @(negedge clk);
    bus.inst_valid = 1'b1;
    bus.Inst_code  = 32'h0022_1820;
    @(negedge clk);                 // DECODE
    bus.inst_valid = 1'b0;
    @(negedge clk);                 // EXEC
    rst = 1'b0;
    #1;
    check_eq("arst_out", {bus.Write_Reg, bus.done, bus.ZF, bus.OF, bus.illegal}, 0);
    check_eq("arst_addr", {bus.W_Addr, bus.ALU_OP}, 0);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check_eq("arst_nowr", bus.Write_Reg, 0);
    end
    rst = 1'b1;
    @(negedge clk);
    check_eq("arst_ready", bus.inst_ready, 1);
    run_legal("post_rst", 32'h0000_0827, ALU_NOR, 5'd0, 5'd0, 5'd1, 1'b1, 1'b0, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Absolute time bound so the run always ends
  initial begin
    #100000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/cpu_ctrl.md
# cpu_ctrl

Multi-cycle controller that sequences the single-cycle R-type datapath (register file plus 3-bit ALU) one instruction at a time. It accepts a 32-bit MIPS R-type instruction over a valid/ready handshake and decodes it. It then drives the register-file read/write addresses, the write enable and ALU_OP in a fixed four-state sequence, and latches the ALU flags. It sits between the instruction source and the existing register file and ALU inside the CPU top level.

## Interface
- REG_ADDR_W, 5, register-file address width (fields Inst_code[25:21]/[20:16]/[15:11] are always 5 bits; wider values zero-extend)
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-low reset (0 = reset)
- inst_valid  in  1  instruction offered
- Inst_code  in  32  instruction word
- inst_ready  out  1  controller can accept; high only in IDLE
- R_Addr_A  out  REG_ADDR_W  read port A address (rs)
- R_Addr_B  out  REG_ADDR_W  read port B address (rt)
- W_Addr  out  REG_ADDR_W  write address (rd)
- Write_Reg  out  1  register-file write enable, single-cycle pulse
- ALU_OP  out  3  ALU operation select
- ALU_ZF, ALU_OF  in  1 each  combinational flags from the ALU
- ZF, OF  out  1 each  flags latched from the last executed instruction
- done  out  1  one-cycle pulse in the WB cycle
- illegal  out  1  one-cycle pulse on a rejected instruction

## Operation
- States: IDLE -> DECODE -> EXEC -> WB -> IDLE. Reject path: DECODE -> IDLE.
- IDLE: inst_ready=1. When inst_valid&inst_ready, latch Inst_code into ir and go to DECODE.
- DECODE: drive R_Addr_A=ir[25:21], R_Addr_B=ir[20:16], W_Addr=ir[15:11] and ALU_OP from funct ir[5:0].
- Legal instructions: opcode ir[31:26]=0 and funct in the map below. On an illegal instruction: pulse illegal, return to IDLE, no write, flags unchanged.
- funct map: 0x24 AND->000, 0x25 OR->001, 0x26 XOR->010, 0x27 NOR->011, 0x20 ADD->100, 0x22 SUB->101, 0x2B SLTU->110, 0x04 SLLV->111.
- EXEC: addresses and ALU_OP stay stable. At the end of the cycle, ZF<=ALU_ZF and OF<=ALU_OF.
- WB: Write_Reg=1 unless W_Addr==0 (r0 is never written) or the overflow trap fires (see Configuration). done=1.
- Addresses and ALU_OP hold their last values outside DECODE..WB. Only Write_Reg gates writes.

## Timing
- Reset (rst=0, asynchronous): state=IDLE, ir=0, all address outputs 0, ALU_OP=000, Write_Reg=0, ZF=0, OF=0, done=0, illegal=0, inst_ready=1 once rst is deasserted.
- Accept at edge N; DECODE in cycle N+1; EXEC in N+2; Write_Reg/done in N+3; inst_ready high again in N+4. Throughput is 1 instruction per 4 cycles.
- illegal pulses in cycle N+1; inst_ready is high again in N+2.
- inst_valid while busy is ignored. The source must hold Inst_code until accepted.
- Reset asserted mid-sequence aborts the instruction at once. No Write_Reg pulse follows.

## Configuration
- CPU_CTRL_OF_TRAP_EN defined: for ADD/SUB with OF latched 1, Write_Reg is suppressed in WB and illegal pulses together with done.
- Not defined: the write always occurs (subject to rd!=0). OF is only reported.

## Structure
- Shared package cpu_pkg holds: ALU_OP constants (ALU_AND..ALU_SLLV), funct codes, the state enum and REG_ADDR_W default.
- One sub-module, cpu_decode: combinational funct/opcode -> {ALU_OP, legal}. The FSM and registers stay in cpu_ctrl.

## Test plan
- Reset, then offer 0x00000827 (NOR r1=r0 nor r0) -> accepted at edge 0. In WB: ALU_OP=011, R_Addr_A=R_Addr_B=0, W_Addr=1, Write_Reg=1 for exactly one cycle, done=1. ZF=0 with ALU_ZF=0.
- Back-to-back valid with ADD 0x00221820 and SUB 0x00221822 -> second accepted 4 cycles after first. ALU_OP 100 then 101. W_Addr=3 both times.
- Opcode 0x08 or funct 0x3F -> illegal pulses at cycle N+1, no Write_Reg, ZF/OF unchanged, inst_ready high at N+2.
- rd=0 (0x00220020) -> done pulses, Write_Reg stays 0.
- ADD with ALU_OF=1 -> OF=1. With CPU_CTRL_OF_TRAP_EN: Write_Reg=0 and illegal=1 in WB. Without: Write_Reg=1.
- rst=0 during EXEC -> outputs reset immediately, no write. After rst=1: inst_ready=1 and the next instruction executes normally.
